latency_multi: RTL

Multi-channel interrupt/SPI latency probe, the parametrised successor of the single-channel latency tester. It drives NCH interrupt lines round-robin and measures two things per channel: the cycles from interrupt assertion until the host acknowledges on that channel's int_ack, and the cycles from acknowledge until the host asserts SPI select. It then serves the result as a byte frame to an external SPI slave. It sits between the SPI byte engine and the board pins, and its status goes to the LEDs.

---
 rtl/latency_multi_if.sv | 24 ++
 rtl/latency_multi.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/latency_multi_if.sv
// latency_multi_if: the probe's pin-side handshake bundle.
// The master modport is the probe (drives irq and the SPI transmit byte).
// The slave modport is the host/SPI side (drives acks, select and byte strobes).
interface latency_multi_if #(
    parameter int NCH = 2
);
    logic [NCH-1:0] int_ack;
    logic           ssel;
    logic           byte_done;
    logic [NCH-1:0] irq;
    logic [7:0]     tx_byte;
    logic [3:0]     cur_ch;
    logic           busy;

    modport master (
        input  int_ack, ssel, byte_done,
        output irq, tx_byte, cur_ch, busy
    );

    modport slave (
        output int_ack, ssel, byte_done,
        input  irq, tx_byte, cur_ch, busy
    );
endinterface

// File: rtl/latency_multi.sv
// latency_multi: round-robin interrupt/SPI latency probe.
// For each channel it raises irq, measures cycles until the debounced ack and
// then until SPI select, and serves {header, status, ack_lat, spi_lat} as a
// byte frame to the SPI slave.
// Optional feature macro: LATENCY_TIMEOUT_EN (bounds the ack and SPI waits by
// TIMEOUT cycles). Without it the waits are unbounded and TIMEOUT is only
// range-checked.
module latency_multi #(
    parameter int NCH     = 2,
    parameter int CNT_W   = 32,
    parameter int PERIOD  = 100000,
    parameter int DEB_LEN = 10,
    parameter int TIMEOUT = 5000000
) (
    input  logic            clk,
    input  logic            rst,
    latency_multi_if.master bus
);

    localparam int NB    = 2 + 2 * CNT_W / 8;
    localparam int PER_W = (PERIOD < 2) ? 1 : $clog2(PERIOD + 1);

    if (NCH < 1 || NCH > 16 || (CNT_W % 8) != 0 || CNT_W < 16 || CNT_W > 32 ||
        DEB_LEN < 3 || PERIOD < 1 || TIMEOUT < 1) begin : g_cfg_check
        $error("latency_multi: parameter set out of range");
    end

    typedef enum logic [2:0] {
        S_BOOT,
        S_WAIT,
        S_IRQ,
        S_SPI,
        S_XFER,
        S_DONE
    } state_t;

    state_t                        state;
    logic [NCH-1:0][DEB_LEN-1:0]   deb_sr;
    logic [NCH-1:0]                ack_deb;
    logic [15:0]                   ack_pad;
    logic                          ack_cur;
    logic [NCH-1:0]                ch_onehot;
    logic [3:0]                    ch_next;

    logic [PER_W-1:0]              per_cnt;
    logic [CNT_W-1:0]              ack_cnt;
    logic [CNT_W-1:0]              spi_cnt;
    logic [CNT_W-1:0]              ack_lat;
    logic [CNT_W-1:0]              spi_lat;
    logic [3:0]                    idx;
    logic                          ack_to;
    logic                          ack_sat;
    logic                          spi_sat;
    logic [7:0]                    status;

    logic [NCH-1:0]                irq_r;
    logic [7:0]                    tx_r;
    logic [3:0]                    ch_r;
    logic                          busy_r;

    // Byte n of the result frame; anything past the last byte reads as 0.
    function automatic logic [7:0] frame_at(
        input logic [3:0]       n,
        input logic [3:0]       ch,
        input logic [7:0]       st,
        input logic [CNT_W-1:0] al,
        input logic [CNT_W-1:0] sl
    );
        logic [7:0] b;
        b = 8'h00;
        if (n == 4'd0) begin
            b = {4'hA, ch};
        end else if (n == 4'd1) begin
            b = st;
        end
        for (int k = 0; k < CNT_W / 8; k++) begin
            if (int'(n) == 2 + k) begin
                b = al[8*k +: 8];
            end
            if (int'(n) == 2 + CNT_W / 8 + k) begin
                b = sl[8*k +: 8];
            end
        end
        return b;
    endfunction

    // The channel under test selects its debounced ack; padding to 16 keeps
    // the 4-bit channel index in range for any NCH.
    assign ack_pad   = 16'(ack_deb);
    assign ack_cur   = ack_pad[ch_r];
    assign ch_onehot = NCH'(16'd1 << ch_r);
    assign ch_next   = (ch_r == 4'(NCH - 1)) ? 4'd0 : ch_r + 4'd1;
    assign status    = {5'b00000, spi_sat, ack_sat, ack_to};

    // Debounce every raw ack: the filtered level only changes once the
    // upper DEB_LEN-1 stages agree, so short glitches never get through.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_sr  <= '1;
            ack_deb <= '1;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                deb_sr[i] <= {deb_sr[i][DEB_LEN-2:0], bus.int_ack[i]};
                if (&deb_sr[i][DEB_LEN-1:1]) begin
                    ack_deb[i] <= 1'b1;
                end else if (~|deb_sr[i][DEB_LEN-1:1]) begin
                    ack_deb[i] <= 1'b0;
                end
            end
        end
    end

    // Measurement sequencer: period wait, irq/ack timing, SPI select timing
    // and frame transmission, with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_BOOT;
            per_cnt <= '0;
            ack_cnt <= '0;
            spi_cnt <= '0;
            ack_lat <= '0;
            spi_lat <= '0;
            idx     <= '0;
            ack_to  <= 1'b0;
            ack_sat <= 1'b0;
            spi_sat <= 1'b0;
            irq_r   <= '0;
            tx_r    <= '0;
            ch_r    <= '0;
            busy_r  <= 1'b0;
        end else begin
            case (state)
                S_BOOT: begin
                    // The host's dummy transfer shows the SPI link is alive.
                    if (bus.byte_done) begin
                        ch_r    <= '0;
                        per_cnt <= '0;
                        busy_r  <= 1'b0;
                        state   <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    // A held ack freezes the idle period rather than restarting it.
                    if (!ack_cur) begin
                        if (per_cnt == PER_W'(PERIOD)) begin
                            irq_r   <= ch_onehot;
                            per_cnt <= '0;
                            ack_cnt <= '0;
                            ack_to  <= 1'b0;
                            busy_r  <= 1'b1;
                            state   <= S_IRQ;
                        end else begin
                            per_cnt <= per_cnt + PER_W'(1);
                        end
                    end
                end

                S_IRQ: begin
                    if (ack_cur) begin
                        // Remove the debounce delay from the raw count.
                        ack_lat <= (ack_cnt > CNT_W'(DEB_LEN - 1)) ?
                                   ack_cnt - CNT_W'(DEB_LEN - 1) : '0;
                        ack_sat <= &ack_cnt;
                        irq_r   <= '0;
                        spi_cnt <= '0;
                        state   <= S_SPI;
                    end
`ifdef LATENCY_TIMEOUT_EN
                    else if (ack_cnt == CNT_W'(TIMEOUT)) begin
                        ack_to  <= 1'b1;
                        ack_lat <= CNT_W'(TIMEOUT);
                        ack_sat <= &ack_cnt;
                        irq_r   <= '0;
                        spi_cnt <= '0;
                        state   <= S_SPI;
                    end
`endif
                    else if (!(&ack_cnt)) begin
                        ack_cnt <= ack_cnt + CNT_W'(1);
                    end
                end

                S_SPI: begin
                    if (!bus.ssel) begin
                        spi_lat <= spi_cnt;
                        spi_sat <= &spi_cnt;
                        idx     <= '0;
                        tx_r    <= frame_at(4'd0, ch_r, status, ack_lat, spi_cnt);
                        state   <= S_XFER;
                    end
`ifdef LATENCY_TIMEOUT_EN
                    else if (spi_cnt == CNT_W'(TIMEOUT)) begin
                        // Host never selected us: drop this result and move on.
                        ch_r    <= ch_next;
                        per_cnt <= '0;
                        busy_r  <= 1'b0;
                        state   <= S_WAIT;
                    end
`endif
                    else if (!(&spi_cnt)) begin
                        spi_cnt <= spi_cnt + CNT_W'(1);
                    end
                end

                S_XFER: begin
                    // A byte strobe wins over select release so the byte in
                    // flight is counted before the abort.
                    if (bus.byte_done) begin
                        idx  <= idx + 4'd1;
                        tx_r <= frame_at(idx + 4'd1, ch_r, status, ack_lat, spi_lat);
                        if (idx == 4'(NB - 1)) begin
                            state <= S_DONE;
                        end
                    end else if (bus.ssel) begin
                        state <= S_DONE;
                    end
                end

                S_DONE: begin
                    if (bus.ssel) begin
                        tx_r    <= '0;
                        ch_r    <= ch_next;
                        per_cnt <= '0;
                        busy_r  <= 1'b0;
                        state   <= S_WAIT;
                    end
                end

                default: begin
                    irq_r  <= '0;
                    busy_r <= 1'b0;
                    state  <= S_BOOT;
                end
            endcase
        end
    end

    assign bus.irq     = irq_r;
    assign bus.tx_byte = tx_r;
    assign bus.cur_ch  = ch_r;
    assign bus.busy    = busy_r;

endmodule
